// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared widths, FSM encodings and lane helper for the ROM loader
package loader_pkg;
  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [SDRAM_DATA_WIDTH-1:0] lane_insert(
    input logic [SDRAM_DATA_WIDTH-1:0] word,
    input logic [1:0]                  lane,
    input logic [7:0]                  data
  );
    logic [SDRAM_DATA_WIDTH-1:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction
endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// rtl/ioctl_sdram_loader_if.sv - ioctl download port plus SDRAM write request bus
interface ioctl_sdram_loader_if;
  import loader_pkg::*;

  logic                        ioctl_download;
  logic                        ioctl_wr;
  logic [24:0]                 ioctl_addr;
  logic [7:0]                  ioctl_data;
  logic                        ioctl_wait;
  logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr;
  logic [SDRAM_DATA_WIDTH-1:0] sdram_data;
  logic                        sdram_we;
  logic                        sdram_req;
  logic                        sdram_ack;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, sdram_ack,
    output ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, sdram_ack,
    input  ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req
  );
endinterface

// File: rtl/ioctl_sdram_loader.sv
// rtl/ioctl_sdram_loader.sv - packs hps_io download bytes into 32-bit SDRAM writes
module ioctl_sdram_loader
  import loader_pkg::*;
#(
  parameter logic [SDRAM_ADDR_WIDTH-1:0] BASE_ADDR = 23'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ioctl_sdram_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  logic [SDRAM_DATA_WIDTH-1:0] asm_data, asm_data_n, merged, fresh, load_data, pend_data;
  logic [SDRAM_ADDR_WIDTH-1:0] pend_addr;
  logic [21:0] asm_tag, asm_tag_n, tag_in, load_tag;
  logic [3:0]  asm_mask, asm_mask_n, lane_bit;
  logic [1:0]  lane, state;
  logic pend_full, pend_full_n, load_pend, ack_take, ovf_set;
  logic byte_acc, asm_done, tag_miss, need_move;
  logic req_q, wait_q, done_q, ovf_q, wrote_any, dl_q;
  logic unused_addr_msb;

  assign unused_addr_msb = bus.ioctl_addr[24];

  assign byte_acc    = bus.ioctl_wr & bus.ioctl_download;
  assign tag_in      = bus.ioctl_addr[23:2];
  assign lane        = bus.ioctl_addr[1:0];
  assign lane_bit    = 4'b0001 << lane;
  assign merged      = lane_insert(asm_data, lane, bus.ioctl_data);
  assign fresh       = lane_insert({SDRAM_DATA_WIDTH{1'b0}}, lane, bus.ioctl_data);
  // A partial word is finished by lane 3, by the download ending, or by a byte for another word.
  assign asm_done    = (|asm_mask) & (asm_mask[3] | ~bus.ioctl_download);
  assign tag_miss    = byte_acc & (|asm_mask) & (tag_in != asm_tag);
  assign need_move   = asm_done | tag_miss;
  assign ack_take    = (state == ST_REQ) & bus.sdram_ack;
  assign pend_full_n = load_pend | (pend_full & ~ack_take);

  always_comb begin
    load_pend  = 1'b0;
    load_data  = asm_data;
    load_tag   = asm_tag;
    asm_data_n = asm_data;
    asm_mask_n = asm_mask;
    asm_tag_n  = asm_tag;
    ovf_set    = 1'b0;
    if (need_move) begin
      if (!pend_full) begin
        load_pend  = 1'b1;
        asm_data_n = byte_acc ? fresh : {SDRAM_DATA_WIDTH{1'b0}};
        asm_mask_n = byte_acc ? lane_bit : 4'b0000;
        asm_tag_n  = tag_in;
      end else begin
        ovf_set = byte_acc;
      end
    end else if (byte_acc) begin
      // Lane 3 with an empty slot bypasses assembly so the request goes out one cycle sooner.
      if (lane_bit[3] && !pend_full) begin
        load_pend  = 1'b1;
        load_data  = merged;
        load_tag   = tag_in;
        asm_data_n = {SDRAM_DATA_WIDTH{1'b0}};
        asm_mask_n = 4'b0000;
      end else begin
        asm_data_n = merged;
        asm_mask_n = asm_mask | lane_bit;
      end
      asm_tag_n = tag_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_data  <= '0;
      asm_mask  <= '0;
      asm_tag   <= '0;
      pend_full <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      state     <= ST_IDLE;
      req_q     <= 1'b0;
      wait_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wrote_any <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      asm_data  <= asm_data_n;
      asm_mask  <= asm_mask_n;
      asm_tag   <= asm_tag_n;
      pend_full <= pend_full_n;
      wait_q    <= pend_full_n;
      dl_q      <= bus.ioctl_download;
      if (load_pend) begin
        pend_addr <= {load_tag, 1'b0} + BASE_ADDR;
        pend_data <= load_data;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (bus.ioctl_download && !dl_q) wrote_any <= 1'b0;
      else if (ack_take)               wrote_any <= 1'b1;
      done_q <= (state == ST_GAP) & ~bus.ioctl_download & ~(|asm_mask) & ~pend_full & wrote_any;
      case (state)
        ST_IDLE: if (pend_full) begin
          state <= ST_REQ;
          req_q <= 1'b1;
        end
        ST_REQ: if (bus.sdram_ack) begin
          state <= ST_GAP;
          req_q <= 1'b0;
        end
        // A word loaded during the gap is requested straight away, keeping req low one cycle.
        ST_GAP: if (load_pend) begin
          state <= ST_REQ;
          req_q <= 1'b1;
        end else begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.sdram_addr = pend_addr;
  assign bus.sdram_data = pend_data;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_we   = req_q;
  assign busy           = bus.ioctl_download | pend_full | (|asm_mask) | (state != ST_IDLE);
  assign done           = done_q;
  assign overflow       = ovf_q;
endmodule
